// File: rtl/data_mem_bridge_pkg.sv
// Shared types and constants for the data-port to external-bus bridge.
package data_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned BYTE_OFF_W  = 2;
  localparam int unsigned WORD_ADDR_W = 30;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle counter for bus wait time; expire flags the last allowed wait cycle.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_bridge.sv
// Turns single-cycle core data accesses into req/ack bus transactions,
// stalling the PC until completion, with timeout and misalignment errors.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = $clog2(TIMEOUT + 1),
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_strobe,
  input  logic                   mem_write,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   pc_ready,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic [31:0]            bus_wdata,
  input  logic                   bus_ack,
  input  logic [31:0]            bus_rdata,
  output logic                   err,
  output logic [31:0]            err_addr
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_bus_we;
  logic [WORD_ADDR_W-1:0] r_bus_addr;
  logic [31:0]            r_bus_wdata;
  logic [31:0]            r_rdata;
  logic                   r_err;
  logic [31:0]            r_err_addr;

  logic w_aligned;
  logic w_issue;
  logic w_misalign;
  logic w_in_req;
  logic w_expire;
  logic w_abort;
  logic w_cnt_en;

  assign w_aligned  = (addr[BYTE_OFF_W-1:0] == '0);
  assign w_issue    = (r_state == IDLE) && mem_strobe && w_aligned;
  assign w_misalign = (r_state == IDLE) && mem_strobe && !w_aligned;
  assign w_in_req   = (r_state == REQ);
  // An ack arriving on the expiry cycle still counts as success.
  assign w_abort    = w_in_req && !bus_ack && w_expire;
  assign w_cnt_en   = w_in_req && !bus_ack && !w_expire;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_issue),
    .i_en     (w_cnt_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // DONE ignores mem_strobe: it still belongs to the completing instruction.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_issue)         w_next = REQ;
        else if (w_misalign) w_next = DONE;
      end
      REQ: begin
        if (bus_ack || w_expire) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      if (w_issue) begin
        r_bus_we    <= mem_write;
        r_bus_addr  <= addr[31:BYTE_OFF_W];
        r_bus_wdata <= wdata;
      end
      if (w_in_req && bus_ack && !r_bus_we) begin
        r_rdata <= bus_rdata;
      end else if (w_misalign || (w_abort && !r_bus_we)) begin
        r_rdata <= ERR_DATA;
      end
      // Only the first fault address is kept until reset.
      if (w_misalign || w_abort) begin
        r_err <= 1'b1;
        if (!r_err) begin
          r_err_addr <= w_misalign ? addr : {r_bus_addr, {BYTE_OFF_W{1'b0}}};
        end
      end
    end
  end

  assign pc_ready  = ((r_state == IDLE) && !mem_strobe) || (r_state == DONE);
  assign bus_req   = w_in_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge, built with TIMEOUT=4.
module tb_data_mem_bridge;

  logic        clk;
  logic        reset;
  logic        mem_strobe;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        pc_ready;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err;
  logic [31:0] err_addr;

  int checks;
  int failures;
  int req_cycles;

  data_mem_bridge #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_strobe (mem_strobe),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .pc_ready   (pc_ready),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .err        (err),
    .err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus_req === 1'b1) req_cycles <= req_cycles + 1;

  // One core cycle: drive at the falling edge, sample 1ns later.
  task automatic step(input logic s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic ack, input logic [31:0] rd);
    @(negedge clk);
    mem_strobe = s; mem_write = w; addr = a; wdata = d;
    bus_ack = ack; bus_rdata = rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_strobe = 1'b0; bus_ack = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_strobe = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #12;
    checks++;
    if ({pc_ready, bus_req, bus_we, err} !== 4'b1000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=1000", {pc_ready, bus_req, bus_we, err});
    end
    checks++;
    if ({rdata, err_addr, bus_wdata, 2'b00, bus_addr} !== 128'd0) begin
      failures++; $display("FAIL reset_data rdata=%h err_addr=%h bus_wdata=%h bus_addr=%h exp=0",
                           rdata, err_addr, bus_wdata, bus_addr);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ldr();
    logic [3:0] pcs;
    logic [3:0] reqs;
    step(1, 0, 32'h100, 32'h0, 0, 32'h0);          pcs[3] = pc_ready; reqs[3] = bus_req;
    step(1, 0, 32'h100, 32'h0, 0, 32'h0);          pcs[2] = pc_ready; reqs[2] = bus_req;
    checks++;
    if (bus_addr !== 30'h40) begin
      failures++; $display("FAIL ldr_bus_addr got=%h exp=40", bus_addr);
    end
    step(1, 0, 32'h100, 32'h0, 1, 32'h12345678);   pcs[1] = pc_ready; reqs[1] = bus_req;
    step(1, 0, 32'h100, 32'h0, 0, 32'h0);          pcs[0] = pc_ready; reqs[0] = bus_req;
    checks++;
    if (pcs !== 4'b0001) begin
      failures++; $display("FAIL ldr_pc_ready got=%b exp=0001", pcs);
    end
    checks++;
    if (reqs !== 4'b0110) begin
      failures++; $display("FAIL ldr_bus_req got=%b exp=0110", reqs);
    end
    checks++;
    if (rdata !== 32'h12345678) begin
      failures++; $display("FAIL ldr_rdata got=%h exp=12345678", rdata);
    end
    step(0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_str();
    logic [2:0] pcs;
    step(1, 1, 32'h204, 32'hCAFEF00D, 0, 32'h0);   pcs[2] = pc_ready;
    step(1, 1, 32'h204, 32'hCAFEF00D, 1, 32'h55555555); pcs[1] = pc_ready;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b1, 30'h81, 32'hCAFEF00D}) begin
      failures++; $display("FAIL str_bus got req=%b we=%b addr=%h wdata=%h exp req=1 we=1 addr=81 wdata=cafef00d",
                           bus_req, bus_we, bus_addr, bus_wdata);
    end
    step(1, 1, 32'h204, 32'hCAFEF00D, 0, 32'h0);   pcs[0] = pc_ready;
    checks++;
    if (pcs !== 3'b001) begin
      failures++; $display("FAIL str_pc_ready got=%b exp=001", pcs);
    end
    checks++;
    if ({err, rdata} !== {1'b0, 32'h12345678}) begin
      failures++; $display("FAIL str_err_rdata got err=%b rdata=%h exp err=0 rdata=12345678", err, rdata);
    end
    step(0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_misaligned();
    logic [1:0] pcs;
    logic [1:0] reqs;
    step(1, 0, 32'h102, 32'h0, 0, 32'h0);          pcs[1] = pc_ready; reqs[1] = bus_req;
    step(1, 0, 32'h102, 32'h0, 0, 32'h0);          pcs[0] = pc_ready; reqs[0] = bus_req;
    checks++;
    if ({pcs, reqs} !== 4'b0100) begin
      failures++; $display("FAIL mis_pc_req got pc=%b req=%b exp pc=01 req=00", pcs, reqs);
    end
    checks++;
    if ({err, err_addr, rdata} !== {1'b1, 32'h102, 32'hDEADBEEF}) begin
      failures++; $display("FAIL mis_err got err=%b err_addr=%h rdata=%h exp err=1 err_addr=102 rdata=deadbeef",
                           err, err_addr, rdata);
    end
    step(0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_timeout();
    int base;
    base = req_cycles;
    step(1, 0, 32'h300, 32'h0, 0, 32'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 32'h300, 32'h0, 0, 32'h0);
    step(1, 0, 32'h300, 32'h0, 0, 32'h0);
    checks++;
    if (req_cycles - base !== 4) begin
      failures++; $display("FAIL to_req_cycles got=%0d exp=4", req_cycles - base);
    end
    checks++;
    if ({pc_ready, bus_req, err, err_addr, rdata} !== {1'b1, 1'b0, 1'b1, 32'h300, 32'hDEADBEEF}) begin
      failures++; $display("FAIL to_done got pc=%b req=%b err=%b err_addr=%h rdata=%h exp pc=1 req=0 err=1 err_addr=300 rdata=deadbeef",
                           pc_ready, bus_req, err, err_addr, rdata);
    end
    step(0, 0, 32'h0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 6; i++) step(1, 0, 32'h400, 32'h0, 0, 32'h0);
    checks++;
    if ({pc_ready, err, err_addr} !== {1'b1, 1'b1, 32'h300}) begin
      failures++; $display("FAIL to_second got pc=%b err=%b err_addr=%h exp pc=1 err=1 err_addr=300",
                           pc_ready, err, err_addr);
    end
    step(0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_reset_in_req();
    step(1, 0, 32'h500, 32'h0, 0, 32'h0);
    step(1, 0, 32'h500, 32'h0, 0, 32'h0);
    checks++;
    if (bus_req !== 1'b1) begin
      failures++; $display("FAIL rir_pre got req=%b exp=1", bus_req);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus_req, pc_ready, err, err_addr} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL rir_async got req=%b pc=%b err=%b err_addr=%h exp req=0 pc=0 err=0 err_addr=0",
                           bus_req, pc_ready, err, err_addr);
    end
    mem_strobe = 1'b0;
    #1;
    checks++;
    if (pc_ready !== 1'b1) begin
      failures++; $display("FAIL rir_idle got pc=%b exp=1", pc_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 32'h600, 32'h0, 0, 32'h0);
    step(1, 0, 32'h600, 32'h0, 1, 32'h600D600D);
    step(1, 0, 32'h600, 32'h0, 0, 32'h0);
    checks++;
    if ({pc_ready, err, rdata, bus_addr} !== {1'b1, 1'b0, 32'h600D600D, 30'h180}) begin
      failures++; $display("FAIL rir_after got pc=%b err=%b rdata=%h bus_addr=%h exp pc=1 err=0 rdata=600d600d bus_addr=180",
                           pc_ready, err, rdata, bus_addr);
    end
    step(0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_ack_at_expiry();
    step(1, 0, 32'h700, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h700, 32'h0, 0, 32'h0);
    step(1, 0, 32'h700, 32'h0, 1, 32'h11112222);
    step(1, 0, 32'h700, 32'h0, 0, 32'h0);
    checks++;
    if ({pc_ready, err, rdata} !== {1'b1, 1'b0, 32'h11112222}) begin
      failures++; $display("FAIL ack_expiry got pc=%b err=%b rdata=%h exp pc=1 err=0 rdata=11112222",
                           pc_ready, err, rdata);
    end
    step(0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int base;
    base = req_cycles;
    step(1, 0, 32'h10, 32'h0, 0, 32'h0);
    step(1, 0, 32'h10, 32'h0, 1, 32'hAAAA5555);
    step(1, 0, 32'h10, 32'h0, 0, 32'h0);
    checks++;
    if ({pc_ready, bus_req, rdata} !== {1'b1, 1'b0, 32'hAAAA5555}) begin
      failures++; $display("FAIL b2b_first got pc=%b req=%b rdata=%h exp pc=1 req=0 rdata=aaaa5555",
                           pc_ready, bus_req, rdata);
    end
    step(1, 0, 32'h20, 32'h0, 0, 32'h0);
    checks++;
    if ({pc_ready, bus_req} !== 2'b00) begin
      failures++; $display("FAIL b2b_no_reissue got pc=%b req=%b exp pc=0 req=0", pc_ready, bus_req);
    end
    step(1, 0, 32'h20, 32'h0, 1, 32'h0BADF00D);
    checks++;
    if (bus_addr !== 30'h08) begin
      failures++; $display("FAIL b2b_addr got=%h exp=08", bus_addr);
    end
    step(1, 0, 32'h20, 32'h0, 0, 32'h0);
    checks++;
    if ({pc_ready, rdata} !== {1'b1, 32'h0BADF00D}) begin
      failures++; $display("FAIL b2b_second got pc=%b rdata=%h exp pc=1 rdata=0badf00d", pc_ready, rdata);
    end
    step(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checks++;
    if (req_cycles - base !== 2) begin
      failures++; $display("FAIL b2b_req_cycles got=%0d exp=2", req_cycles - base);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    req_cycles = 0;
    test_reset();
    test_ldr();
    test_str();
    test_misaligned();
    do_reset();
    test_timeout();
    test_reset_in_req();
    test_ack_at_expiry();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
